exp_dispatch: RTL and testbench

Request sequencer directly upstream of `expTop` (Maclaurin exponential core). It accepts Q0.16 arguments over a valid/ready stream and queues them in a small FIFO. Each argument is issued to the core as a one-cycle `start` with a stable `xBus`, and the 18-bit Q2.16 `rBus` result is captured on `done` and returned over a valid/ready output stream. It makes the start/done core usable from pipelined producers and consumers without dropping requests.

---
 rtl/exp_dispatch.sv | 148 ++++++++++++++
 tb/tb_exp_dispatch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_dispatch.sv
`timescale 1ns/1ps
// exp_dispatch: request sequencer in front of expTop; queues Q0.16 args, issues start/xBus, returns Q2.16 rBus.
// Latency: push at edge 0 pops at edge 1, startOut high for the following cycle; result valid the cycle after a sampled doneIn rising edge.
// Backpressure: inReady = registered count < DEPTH; a captured result is held on outR/outValid until outReady.
// Ports: inValid/inReady/inX argument stream; startOut/xOut/doneIn/rIn expTop handshake;
//        outValid/outReady/outR/outErr result stream; busy = FSM not IDLE or FIFO non-empty.
// Option: define EXP_DISPATCH_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles (outR=3FFFF, outErr=1).
module exp_dispatch #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        inValid,
  output logic        inReady,
  input  logic [15:0] inX,
  output logic        startOut,
  output logic [15:0] xOut,
  input  logic        doneIn,
  input  logic [17:0] rIn,
  output logic        outValid,
  input  logic        outReady,
  output logic [17:0] outR,
  output logic        outErr,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  logic [1:0]    state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          done_q;
  logic          push;
  logic          pop;
  logic          done_rise;

  // Ready depends on the registered count only, so a full FIFO refuses a
  // push even in the cycle it is being popped.
  assign inReady   = (count < CW'(DEPTH));
  assign push      = inValid && inReady;
  assign pop       = (state == ST_IDLE) && (count != '0);
  // Only a fresh rising edge counts; a level left high by the previous
  // operation must be seen low first.
  assign done_rise = doneIn && !done_q;
  assign startOut  = (state == ST_LAUNCH);
  assign busy      = (state != ST_IDLE) || (count != '0);

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= inX;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef EXP_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign outErr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= ST_IDLE;
      xOut     <= '0;
      outValid <= 1'b0;
      outR     <= '0;
      done_q   <= 1'b0;
`ifdef EXP_DISPATCH_TIMEOUT_EN
      outErr   <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
      done_q <= doneIn;
      case (state)
        ST_IDLE: begin
          // xOut changes only here, so it stays stable for the whole op.
          if (pop) begin
            xOut  <= mem[rd_ptr];
            state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
`ifdef EXP_DISPATCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_rise) begin
            outR     <= rIn;
            outValid <= 1'b1;
            state    <= ST_HOLD;
`ifdef EXP_DISPATCH_TIMEOUT_EN
            outErr   <= 1'b0;
          end else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
            // Last permitted WAIT cycle with no completion: abort.
            outR     <= 18'h3FFFF;
            outErr   <= 1'b1;
            outValid <= 1'b1;
            state    <= ST_HOLD;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
`endif
          end
        end
        ST_HOLD: begin
          if (outReady) begin
            outValid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_dispatch.sv
`timescale 1ns/1ps
module tb_exp_dispatch;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [15:0] inX;
  logic        startOut;
  logic [15:0] xOut;
  logic        doneIn;
  logic [17:0] rIn;
  logic        outValid;
  logic        outReady;
  logic [17:0] outR;
  logic        outErr;
  logic        busy;

  always #5 clk = ~clk;

  exp_dispatch #(.DEPTH(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rstN(rstN),
    .inValid(inValid), .inReady(inReady), .inX(inX),
    .startOut(startOut), .xOut(xOut), .doneIn(doneIn), .rIn(rIn),
    .outValid(outValid), .outReady(outReady), .outR(outR), .outErr(outErr),
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stub core result for an argument; chosen so f(4000)=148B6 and f(2BF3)=12345.
  function automatic logic [17:0] f(input logic [15:0] x);
    return {2'b01, x} ^ 18'h008B6;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stub expTop ----------------
  int lat = 10;
  int hold_len = 1;
  int s_cnt = 0, s_hold = 0, s_drop = 0;

  initial begin
    doneIn = 1'b0;
    rIn    = '0;
    forever begin
      @(negedge clk);
      if (startOut) begin
        s_cnt = lat;
        if (doneIn) s_drop = 2;  // stale level: drop after first WAIT cycle
      end else begin
        if (s_drop > 0) begin
          s_drop--;
          if (s_drop == 0) doneIn = 1'b0;
        end
        if (s_cnt > 0) begin
          s_cnt--;
          if (s_cnt == 0) begin
            doneIn = 1'b1;
            rIn    = f(xOut);
            s_hold = hold_len;
          end
        end else if (doneIn && s_drop == 0) begin
          if (s_hold > 1) s_hold--;
          else doneIn = 1'b0;
        end
      end
    end
  end

  // ---------------- model + compare ----------------
  logic [15:0] exp_x[$];
  logic [17:0] exp_r[$];
  bit in_op = 0, prev_start = 0, tmo_mode = 0, thr_mode = 0, arm = 0;
  int arm_cyc = 0, n_results = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rstN) begin
        exp_x.delete();
        exp_r.delete();
        in_op = 0; prev_start = 0; arm = 0;
      end else begin
        if (startOut) begin
          chk("start_one_cycle", prev_start, 0);
          chk("start_has_arg", exp_x.size() > 0, 1);
          if (exp_x.size() > 0) begin
            chk("x_order", xOut, exp_x[0]);
            exp_r.push_back(tmo_mode ? 18'h3FFFF : f(exp_x[0]));
            void'(exp_x.pop_front());
          end
          in_op = 1;
          if (arm) begin
            chk("thr_start_gap", cyc, arm_cyc);
            arm = 0;
          end
        end
        prev_start = startOut;
        chk("in_ready", inReady, exp_x.size() < 4);
        chk("busy", busy, in_op || exp_x.size() > 0);
        if (outValid) begin
          chk("out_has_op", exp_r.size() > 0, 1);
          if (exp_r.size() > 0) begin
            chk("out_r", outR, exp_r[0]);
            chk("out_err", outErr, tmo_mode);
            if (outReady) begin
              void'(exp_r.pop_front());
              in_op = 0;
              n_results++;
              if (thr_mode && exp_x.size() > 0) begin
                arm = 1;
                arm_cyc = cyc + 2;
              end
            end
          end
        end
        if (inValid && inReady) exp_x.push_back(inX);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] x);
    int n;
    n = 0;
    inValid = 1'b1;
    inX = x;
    @(negedge clk);
    while (!inReady && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", inReady, 1);
    step();
    inValid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || outValid) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"}, startOut, 0);
    chk({tag, "_xout"}, xOut, 0);
    chk({tag, "_ovalid"}, outValid, 0);
    chk({tag, "_outr"}, outR, 0);
    chk({tag, "_oerr"}, outErr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_inready"}, inReady, 1);
  endtask

  initial begin
    int n, r0;
    bit ok;
    rstN = 1'b1; inValid = 1'b0; inX = '0; outReady = 1'b1;
    #1 rstN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    step();
    rstN = 1'b1;

    // Single op with hand-computed timing.
    step();
    lat = 10;
    inValid = 1'b1; inX = 16'h4000;
    @(negedge clk); chk("t1_accept", inReady, 1);
    step(); inValid = 1'b0;
    @(negedge clk); chk("t1_no_start_yet", startOut, 0);
    @(negedge clk); chk("t1_start", startOut, 1); chk("t1_xout", xOut, 16'h4000);
    @(negedge clk); chk("t1_start_width", startOut, 0);
    n = 1;
    while (!outValid && n < 100) begin @(negedge clk); n++; end
    chk("t1_result_latency", n, 11);
    chk("t1_outr", outR, 18'h148B6);
    chk("t1_oerr", outErr, 0);
    chk("t1_xout_stable", xOut, 16'h4000);
    wait_idle("t1_idle", 50);

    // FIFO full with output stalled.
    step();
    outReady = 1'b0; lat = 3;
    for (int i = 0; i < 5; i++) push(16'(i + 1) << 12);
    inValid = 1'b1; inX = 16'h6000;
    ok = 1;
    repeat (10) begin @(negedge clk); if (inReady) ok = 0; end
    chk("t2_full_stall", ok, 1);
    r0 = n_results;
    step(); outReady = 1'b1;
    @(negedge clk); chk("t2_first_result", outR, 18'h118B6);
    n = 0;
    while (!inReady && n < 50) begin @(negedge clk); n++; end
    chk("t2_sixth_accept", inReady, 1);
    step(); inValid = 1'b0;
    wait_idle("t2_idle", 500);
    chk("t2_results", n_results - r0, 6);

    // Stale done level from the previous op.
    step();
    lat = 4; hold_len = 1000;
    r0 = n_results;
    push(16'h1111);
    n = 0;
    while (n_results < r0 + 1 && n < 100) begin @(negedge clk); n++; end
    step();
    hold_len = 1;
    push(16'h2BF3);
    n = 0;
    while (n_results < r0 + 2 && n < 100) begin @(negedge clk); n++; end
    chk("t3_results", n_results - r0, 2);
    chk("t3_outr", outR, 18'h12345);
    wait_idle("t3_idle", 50);

    // Reset during WAIT with three queued arguments.
    step();
    lat = 20;
    for (int i = 0; i < 4; i++) push(16'hA001 + 16'(i));
    step(); step();
    rstN = 1'b0;
    @(negedge clk);
    chk_reset_vals("t4");
    step();
    rstN = 1'b1;
    ok = 1;
    repeat (40) begin @(negedge clk); if (outValid || busy) ok = 0; end
    chk("t4_no_late_result", ok, 1);

    // Back-to-back throughput.
    step();
    lat = 5; thr_mode = 1;
    r0 = n_results;
    for (int i = 0; i < 8; i++) push(16'h0100 * 16'(i + 1));
    wait_idle("t5_idle", 600);
    chk("t5_results", n_results - r0, 8);
    step();
    thr_mode = 0;

`ifdef EXP_DISPATCH_TIMEOUT_EN
    // Timeout abort when the core never completes.
    lat = 2000; tmo_mode = 1;
    push(16'h7777);
    n = 0;
    do begin @(negedge clk); n++; end while (!startOut && n < 10);
    chk("t6_start", startOut, 1);
    n = 0;
    while (!outValid && n < 200) begin @(negedge clk); n++; end
    chk("t6_latency", n, 65);
    chk("t6_outr", outR, 18'h3FFFF);
    chk("t6_oerr", outErr, 1);
    wait_idle("t6_idle", 20);
    step();
    tmo_mode = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
